// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, computes the next PC for
// INC/BRANCH/JUMP/CALL/RET/TRAP and keeps a circular return-address stack.
module pc_unit #(
    parameter int unsigned     PC_W      = 11,
    parameter int unsigned     STEP      = 1,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = 11'h7F0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [2:0]                   op,
    input  logic [PC_W-1:0]              imm,
    input  logic [PC_W-1:0]              target,
    input  logic                         flush,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus,
    output logic [PC_W-1:0]              ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf,
    output logic                         illegal_op
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_TRAP   = 3'b101;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic             push_c;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ill_q, ill_d;
    logic [PTR_W-1:0] top_idx_c;

    // Combinational views of PC and stack state
    always_comb begin
        top_idx_c = sp_q - PTR_W'(1);
        pc_plus   = pc_q + PC_W'(STEP);
        ras_empty = (cnt_q == '0);
        ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
        ras_top   = ras_empty ? '0 : mem_q[top_idx_c];
    end

    assign pc         = pc_q;
    assign ras_count  = cnt_q;
    assign ras_ovf    = ovf_q;
    assign ras_unf    = unf_q;
    assign illegal_op = ill_q;

    // Next-state decode for PC, stack pointer, count and pulse flags
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        push_c = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        ill_d  = 1'b0;
        if (we) begin
            case (op)
                OP_INC:    pc_d = pc_plus;
                OP_BRANCH: pc_d = pc_plus + imm;
                OP_JUMP:   pc_d = target;
                OP_CALL: begin
                    pc_d   = target;
                    push_c = 1'b1;
                    sp_d   = sp_q + PTR_W'(1);
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (ras_empty) begin
                        pc_d  = TRAP_VEC;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = ras_top;
                        sp_d  = top_idx_c;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                OP_TRAP:   pc_d = TRAP_VEC;
                default:   ill_d = 1'b1;
            endcase
        end
        // Flush empties the stack; a concurrent push is discarded
        if (flush) begin
            sp_d   = '0;
            cnt_d  = '0;
            push_c = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            ill_q <= ill_d;
            if (push_c) begin
                mem_q[sp_q] <= pc_plus;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized ops
// compared against a queue-based reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, we, flush;
    logic [2:0]  op;
    logic [10:0] imm, target;
    logic [10:0] pc, pc_plus, ras_top;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_ovf, ras_unf, illegal_op;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [10:0] m_pc;
    logic [10:0] m_stack[$];
    logic        m_ovf, m_unf, m_ill;

    localparam logic [10:0] TRAP = 11'h7F0;

    pc_unit dut (
        .clk(clk), .rst(rst), .we(we), .op(op), .imm(imm), .target(target),
        .flush(flush), .pc(pc), .pc_plus(pc_plus), .ras_top(ras_top),
        .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model, return 1 ns after the edge
    task automatic apply(input logic rs, input logic w, input logic [2:0] o,
                         input logic [10:0] im, input logic [10:0] tg, input logic fl);
        logic [10:0] npc;
        logic ov, un, il;
        @(negedge clk);
        rst = rs; we = w; op = o; imm = im; target = tg; flush = fl;
        npc = m_pc; ov = 1'b0; un = 1'b0; il = 1'b0;
        if (rs) begin
            npc = 11'h000;
            m_stack.delete();
        end else begin
            if (w) begin
                case (o)
                    3'd0: npc = m_pc + 11'd1;
                    3'd1: npc = m_pc + 11'd1 + im;
                    3'd2: npc = tg;
                    3'd3: begin
                        npc = tg;
                        if (!fl) begin
                            if (m_stack.size() == 4) begin
                                void'(m_stack.pop_front());
                                ov = 1'b1;
                            end
                            m_stack.push_back(m_pc + 11'd1);
                        end
                    end
                    3'd4: begin
                        if (m_stack.size() == 0) begin
                            npc = TRAP;
                            un  = 1'b1;
                        end else begin
                            npc = m_stack[$];
                            void'(m_stack.pop_back());
                        end
                    end
                    3'd5: npc = TRAP;
                    default: il = 1'b1;
                endcase
            end
            if (fl) m_stack.delete();
        end
        @(posedge clk);
        #1;
        m_pc = npc; m_ovf = ov; m_unf = un; m_ill = il;
        rst = 1'b0; we = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        apply(1, 0, 3'd0, 11'h0, 11'h0, 0);
        apply(1, 1, 3'd3, 11'h0, 11'h155, 0);
        checks++; if (pc !== 11'h000) begin errors++; $display("FAIL reset_pc got=%h want=000", pc); end
        checks++; if (ras_count !== 3'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            errors++; $display("FAIL reset_ras cnt=%0d empty=%b full=%b want 0/1/0", ras_count, ras_empty, ras_full); end
        checks++; if ({ras_ovf, ras_unf, illegal_op} !== 3'b000 || ras_top !== 11'h000) begin
            errors++; $display("FAIL reset_flags got=%b top=%h want=000 top=000", {ras_ovf, ras_unf, illegal_op}, ras_top); end
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 3; i++) begin
            apply(0, 1, 3'd0, 11'h0, 11'h0, 0);
            checks++; if (pc !== 11'(i)) begin errors++; $display("FAIL inc_pc got=%h want=%h", pc, 11'(i)); end
            checks++; if (pc_plus !== 11'(i + 1)) begin errors++; $display("FAIL inc_pc_plus got=%h want=%h", pc_plus, 11'(i + 1)); end
        end
    endtask

    task automatic test_branch_wrap();
        apply(0, 1, 3'd2, 11'h0, 11'h7FE, 0);
        checks++; if (pc_plus !== 11'h7FF) begin errors++; $display("FAIL pc_plus_edge got=%h want=7ff", pc_plus); end
        apply(0, 1, 3'd1, 11'h002, 11'h0, 0);
        checks++; if (pc !== 11'h001) begin errors++; $display("FAIL branch_wrap_fwd got=%h want=001", pc); end
        apply(0, 1, 3'd1, 11'h7FD, 11'h0, 0);
        checks++; if (pc !== 11'h7FF) begin errors++; $display("FAIL branch_wrap_back got=%h want=7ff", pc); end
        checks++; if (pc_plus !== 11'h000) begin errors++; $display("FAIL pc_plus_wrap got=%h want=000", pc_plus); end
    endtask

    task automatic test_call_ret();
        apply(1, 0, 3'd0, 11'h0, 11'h0, 0);
        apply(0, 1, 3'd2, 11'h0, 11'h010, 0);
        apply(0, 1, 3'd3, 11'h0, 11'h100, 0);
        apply(0, 1, 3'd3, 11'h0, 11'h200, 0);
        checks++; if (ras_count !== 3'd2 || ras_top !== 11'h101 || pc !== 11'h200) begin
            errors++; $display("FAIL call_nest cnt=%0d top=%h pc=%h want 2/101/200", ras_count, ras_top, pc); end
        apply(0, 1, 3'd4, 11'h0, 11'h0, 0);
        checks++; if (pc !== 11'h101 || ras_top !== 11'h011) begin errors++; $display("FAIL ret1 pc=%h top=%h want 101/011", pc, ras_top); end
        apply(0, 1, 3'd4, 11'h0, 11'h0, 0);
        checks++; if (pc !== 11'h011 || ras_empty !== 1'b1 || ras_top !== 11'h000) begin
            errors++; $display("FAIL ret2 pc=%h empty=%b top=%h want 011/1/000", pc, ras_empty, ras_top); end
    endtask

    task automatic test_overflow();
        logic [10:0] exp_ret [4];
        exp_ret = '{11'h401, 11'h301, 11'h201, 11'h101};
        apply(1, 0, 3'd0, 11'h0, 11'h0, 0);
        apply(0, 1, 3'd2, 11'h0, 11'h010, 0);
        for (int k = 1; k <= 5; k++) begin
            apply(0, 1, 3'd3, 11'h0, 11'(k * 256), 0);
            checks++; if (ras_ovf !== (k == 5)) begin errors++; $display("FAIL ovf_call%0d got=%b want=%b", k, ras_ovf, (k == 5)); end
        end
        checks++; if (ras_full !== 1'b1 || ras_count !== 3'd4) begin errors++; $display("FAIL ovf_full full=%b cnt=%0d want 1/4", ras_full, ras_count); end
        apply(0, 0, 3'd0, 11'h0, 11'h0, 0);
        checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL ovf_single got=%b want=0", ras_ovf); end
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 3'd4, 11'h0, 11'h0, 0);
            checks++; if (pc !== exp_ret[k]) begin errors++; $display("FAIL ovf_ret%0d got=%h want=%h", k, pc, exp_ret[k]); end
        end
        apply(0, 1, 3'd4, 11'h0, 11'h0, 0);
        checks++; if (pc !== TRAP || ras_unf !== 1'b1) begin errors++; $display("FAIL unf pc=%h unf=%b want 7f0/1", pc, ras_unf); end
    endtask

    task automatic test_flush();
        apply(1, 0, 3'd0, 11'h0, 11'h0, 0);
        apply(0, 1, 3'd3, 11'h0, 11'h050, 0);
        apply(0, 1, 3'd3, 11'h0, 11'h060, 0);
        apply(0, 1, 3'd3, 11'h0, 11'h300, 1);
        checks++; if (pc !== 11'h300 || ras_count !== 3'd0 || ras_ovf !== 1'b0 || ras_top !== 11'h000) begin
            errors++; $display("FAIL call_flush pc=%h cnt=%0d ovf=%b top=%h want 300/0/0/000", pc, ras_count, ras_ovf, ras_top); end
        apply(0, 0, 3'd4, 11'h0, 11'h0, 0);
        checks++; if (pc !== 11'h300 || ras_unf !== 1'b0) begin errors++; $display("FAIL we0_hold pc=%h unf=%b want 300/0", pc, ras_unf); end
        apply(0, 1, 3'd3, 11'h0, 11'h400, 0);
        apply(0, 1, 3'd4, 11'h0, 11'h0, 1);
        checks++; if (pc !== 11'h301 || ras_count !== 3'd0) begin errors++; $display("FAIL ret_flush pc=%h cnt=%0d want 301/0", pc, ras_count); end
        apply(0, 0, 3'd0, 11'h0, 11'h0, 1);
        checks++; if (pc !== 11'h301) begin errors++; $display("FAIL flush_only pc=%h want 301", pc); end
    endtask

    task automatic test_illegal_reset();
        apply(0, 1, 3'd7, 11'h0, 11'h0, 0);
        checks++; if (pc !== 11'h301 || illegal_op !== 1'b1) begin errors++; $display("FAIL illegal pc=%h ill=%b want 301/1", pc, illegal_op); end
        apply(0, 1, 3'd6, 11'h0, 11'h0, 0);
        checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL illegal6 got=%b want=1", illegal_op); end
        apply(0, 0, 3'd7, 11'h0, 11'h0, 0);
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_pulse got=%b want=0", illegal_op); end
        apply(0, 1, 3'd3, 11'h0, 11'h123, 0);
        apply(1, 0, 3'd0, 11'h0, 11'h0, 0);
        checks++; if (pc !== 11'h000 || ras_count !== 3'd0) begin errors++; $display("FAIL midreset pc=%h cnt=%0d want 000/0", pc, ras_count); end
        apply(0, 1, 3'd4, 11'h0, 11'h0, 0);
        checks++; if (pc !== TRAP || ras_unf !== 1'b1) begin errors++; $display("FAIL midreset_ret pc=%h unf=%b want 7f0/1", pc, ras_unf); end
        apply(0, 1, 3'd5, 11'h0, 11'h0, 0);
        checks++; if (pc !== TRAP || ras_unf !== 1'b0) begin errors++; $display("FAIL trap pc=%h unf=%b want 7f0/0", pc, ras_unf); end
    endtask

    task automatic test_random();
        logic [10:0] exp_top;
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                  11'($urandom), 11'($urandom), ($urandom_range(0, 9) == 0));
            exp_top = (m_stack.size() == 0) ? 11'h000 : m_stack[$];
            checks++; if (pc !== m_pc || pc_plus !== m_pc + 11'd1) begin
                errors++; $display("FAIL rnd_pc n=%0d pc=%h pc_plus=%h want %h/%h", n, pc, pc_plus, m_pc, m_pc + 11'd1); end
            checks++; if (ras_count !== 3'(m_stack.size()) || ras_top !== exp_top ||
                          ras_empty !== (m_stack.size() == 0) || ras_full !== (m_stack.size() == 4)) begin
                errors++; $display("FAIL rnd_ras n=%0d cnt=%0d top=%h want %0d/%h", n, ras_count, ras_top, m_stack.size(), exp_top); end
            checks++; if ({ras_ovf, ras_unf, illegal_op} !== {m_ovf, m_unf, m_ill}) begin
                errors++; $display("FAIL rnd_flags n=%0d got=%b want=%b", n, {ras_ovf, ras_unf, illegal_op}, {m_ovf, m_unf, m_ill}); end
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; flush = 1'b0; op = 3'd0; imm = '0; target = '0;
        m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0; m_ill = 1'b0;
        test_reset();
        test_inc();
        test_branch_wrap();
        test_call_ret();
        test_overflow();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the multicycle CPU datapath, replacing the fixed 11-bit write-enabled PC register. It holds the PC and computes the next PC internally for increment, relative branch, absolute jump, call/return and trap. Call/return uses a built-in circular return-address stack (RAS). The control FSM drives `we`/`op` once per instruction in the PC-update state.

Parameters:
- PC_W, 11, PC and address width in bits.
- STEP, 1, increment per sequential instruction, unsigned, < 2^PC_W.
- RAS_DEPTH, 4, number of return-address entries, power of two, >= 2.
- RESET_PC, 0, PC value after reset.
- TRAP_VEC, 11'h7F0, PC loaded on TRAP and on RAS underflow; width PC_W.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- we, in, 1, PC update enable; when 0 no state changes except flush.
- op, in, 3, update operation: 000 INC, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101 TRAP, 110/111 illegal.
- imm, in, PC_W, signed two's-complement branch offset.
- target, in, PC_W, absolute jump/call target.
- flush, in, 1, clears the RAS.
- pc, out, PC_W, current PC (registered).
- pc_plus, out, PC_W, combinational pc+STEP, mod 2^PC_W.
- ras_top, out, PC_W, combinational top-of-stack entry; 0 when empty.
- ras_count, out, clog2(RAS_DEPTH)+1, number of valid entries.
- ras_empty, out, 1, ras_count==0.
- ras_full, out, 1, ras_count==RAS_DEPTH.
- ras_ovf, out, 1, one-cycle registered pulse when a CALL overwrites the oldest entry.
- ras_unf, out, 1, one-cycle registered pulse on RET to an empty stack.
- illegal_op, out, 1, one-cycle registered pulse on `we` with op 110/111.

Behaviour:
- Reset (`rst`=1 at edge, highest priority over everything):
  - pc=RESET_PC, ras_count=0, stack pointer=0, all RAS entries=0.
  - ras_ovf=ras_unf=illegal_op=0.
- Update latency: `pc` takes its new value at the edge where `we`=1. The new value is visible the following cycle.
- Pulse outputs: default 0 each cycle; asserted for exactly the cycle after the causing edge.
- All arithmetic is modulo 2^PC_W; wrap-around is silent, with no flag.
- INC: pc <= pc+STEP.
- BRANCH: pc <= pc+STEP+imm. `imm` is sign-interpreted; e.g. with PC_W=11, imm=11'h7FF means -1.
- JUMP: pc <= target.
- CALL: push pc+STEP; pc <= target.
  - When not full: ras_count increments.
  - When full: the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and ras_ovf pulses.
- RET:
  - Non-empty: pc <= ras_top, pointer decrements, ras_count decrements.
  - Empty: pc <= TRAP_VEC, stack unchanged, ras_unf pulses.
- TRAP: pc <= TRAP_VEC; stack untouched.
- Illegal op: pc and stack unchanged; illegal_op pulses.
- `we`=0: op is ignored, pc holds, and no pulses fire.
- flush=1 (independent of `we`): after the edge, ras_count=0 and pointer=0. The PC effect of a concurrent op still applies:
  - CALL+flush: pc<=target; pushed value discarded; stack empty; no ras_ovf.
  - RET+flush, non-empty: pc<=ras_top; stack empty.
  - RET+flush, empty: TRAP_VEC and ras_unf as normal.
- Entries beyond ras_count are don't-care but must never appear on ras_top (ras_top=0 when empty).
- Reset asserted mid-sequence (e.g. between a CALL and its RET): full reset state. A following RET underflows.

Test Plan:
- Reset/INC: rst for 2 cycles, then we=1 op=INC ×3 → pc 0,1,2,3; pc_plus tracks pc+1; all flags 0.
- Branch wrap: pc=11'h7FE, BRANCH imm=11'h002 → pc=11'h001. Then BRANCH imm=11'h7FD (-3) → pc=11'h7FF.
- Call/return nesting: CALL 0x100 from pc=0x010, then CALL 0x200 → ras_count=2, ras_top=0x101. RET → pc=0x101. RET → pc=0x011, ras_empty=1.
- Overflow: 5 CALLs with RAS_DEPTH=4 → ras_ovf pulses once, on the 5th. Four RETs return the 4 newest addresses in LIFO order. A 5th RET → pc=0x7F0 and ras_unf pulses.
- Flush/simultaneous: 2 entries then CALL+flush target 0x300 → pc=0x300, ras_count=0, no ras_ovf. Then `we`=0 with op=RET → pc holds.
- Illegal and reset mid-op: op=3'b111 with we=1 → pc unchanged, illegal_op one cycle. CALL, then rst, then RET → pc=RESET_PC after rst, then TRAP_VEC and ras_unf.
